keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//  Front-end for the 8-bit digital lock: assembles hex key presses from the keypad
//  scanner into an 8-bit candidate code. Presents it on key_out with a one-cycle
//  enter_out pulse that drives the lock's key_in/enter. Handles clear, incomplete
//  entry, inter-key timeout, and blocks input while the lock is granted or locked out.
// PARAMETERS
//  NUM_DIGITS      2     hex digits per code; code width = 4*NUM_DIGITS (8 at default)
//  TIMEOUT_CYCLES  1000  idle cycles after last accepted key before partial entry is
//                        discarded; 0 disables the timeout
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous reset, active-low
//  key_valid    in   1   one-cycle strobe: a key press is on key_kind/key_digit
//  key_kind     in   2   00=digit 01=clear 10=enter 11=reserved (ignored)
//  key_digit    in   4   hex digit value; used only when key_kind=00
//  lock_busy    in   1   high while downstream lock shows access or lockout
//  key_out      out  8   assembled code (4*NUM_DIGITS bits) -> lock key_in
//  enter_out    out  1   one-cycle submit pulse -> lock enter
//  digit_cnt    out  2   digits currently held (0..NUM_DIGITS)
//  entry_err    out  1   one-cycle pulse: enter pressed with incomplete code
//  timeout      out  1   one-cycle pulse: partial entry discarded by timeout
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): key_out=0, enter_out=0, digit_cnt=0,
//   entry_err=0, timeout=0, timer=0, state=IDLE. Reset overrides all other inputs.
//  States:
//   IDLE    (0 digits)
//   COLLECT (1..NUM_DIGITS-1 digits)
//   FULL    (NUM_DIGITS digits)
//   FIRE    (enter_out=1, exactly one cycle, then -> IDLE)
//  All outputs are registered. A strobe sampled at edge t takes effect at edge t+1.
//  Digit key: buffer <= {buffer[W-5:0], key_digit}, so the first digit ends up in the MSB nibble.
//   digit_cnt++. IDLE->COLLECT, or directly ->FULL when NUM_DIGITS=1.
//  Digit key in FULL: ignored. Buffer, count and timer are unchanged.
//  Clear key: buffer=0, digit_cnt=0, ->IDLE. No pulse. Clear in IDLE is a no-op.
//  Enter key in FULL: ->FIRE. During FIRE, enter_out=1 and key_out holds the full code.
//   Next cycle: key_out=0, digit_cnt=0, ->IDLE.
//  Enter key in IDLE or COLLECT: entry_err=1 for one cycle, buffer and count cleared, ->IDLE.
//  key_kind=11: ignored entirely. It does not restart the timer.
//  Strobes arriving while in FIRE: ignored.
//  Timeout: timer clears on every accepted key and counts up each cycle in COLLECT/FULL.
//   When timer == TIMEOUT_CYCLES-1: timeout=1 for one cycle, buffer cleared, ->IDLE.
//   Timer is held at 0 in IDLE and FIRE. Timer width is clog2(TIMEOUT_CYCLES+1); saturates.
//  lock_busy=1: all strobes ignored, buffer and count cleared, state forced to IDLE,
//   timer held at 0, no pulses. If lock_busy rises while in FIRE, the pulse still
//   completes (it started on the previous edge).
//  Outputs are never simultaneously pulsed: at most one of enter_out/entry_err/timeout per cycle.
//  Key strobes win over a timeout that expires in the same cycle (key accepted, no timeout pulse).
// TESTING
//  1. Digits A,5 then enter -> enter_out=1 one cycle after enter strobe with key_out=8'hA5;
//     next cycle key_out=0, digit_cnt=0.
//  2. Digit 3 then enter -> entry_err pulse, enter_out stays 0, digit_cnt=0.
//  3. Digits 1,2,7 then enter -> digit 7 dropped; enter_out with key_out=8'h12.
//  4. Digit C then clear, digits 0,F, enter -> key_out=8'h0F on enter_out. Clear produces no pulse.
//  5. TIMEOUT_CYCLES=8: digit 9, then idle -> timeout pulses 8 cycles after the accepted key, digit_cnt=0.
//     Repeat with a digit on the expiry cycle -> no timeout, digit_cnt=2.
//  6. lock_busy=1 with digit B held -> digit_cnt=0; digits ignored. rst_n=0 mid-entry
//     (1 digit held) -> all outputs 0 next cycle.

Source files
------------

// File: rtl/keypad_if.sv
// Keypad scanner / lock facing signal bundle for keypad_entry.
// The master side is the scanner plus lock; the slave side is the entry block.
interface keypad_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic          key_valid;
  logic [1:0]    key_kind;
  logic [3:0]    key_digit;
  logic          lock_busy;
  logic [W-1:0]  key_out;
  logic          enter_out;
  logic [CW-1:0] digit_cnt;
  logic          entry_err;
  logic          timeout;

  modport master (
    output key_valid, key_kind, key_digit, lock_busy,
    input  key_out, enter_out, digit_cnt, entry_err, timeout
  );

  modport slave (
    input  key_valid, key_kind, key_digit, lock_busy,
    output key_out, enter_out, digit_cnt, entry_err, timeout
  );
endinterface

// File: rtl/keypad_entry.sv
// Assembles hex key presses into a lock code and issues a one-cycle submit pulse,
// with clear, incomplete-entry error, inter-key timeout and lock-busy blocking.
module keypad_entry #(
  parameter int NUM_DIGITS     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic    clk,
  input  logic    rst_n,
  keypad_if.slave kp
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] NFULL = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, FIRE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          enter_q, enter_d;
  logic          err_q, err_d;
  logic          to_q, to_d;
  logic          key_dig, key_clr, key_ent;

  assign key_dig = kp.key_valid && (kp.key_kind == 2'b00);
  assign key_clr = kp.key_valid && (kp.key_kind == 2'b01);
  assign key_ent = kp.key_valid && (kp.key_kind == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      enter_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      enter_q <= enter_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    enter_d = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    if (state_q == FIRE) begin
      // The submit pulse always completes; everything else waits for IDLE.
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (kp.lock_busy || key_clr) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (key_ent) begin
      timer_d = '0;
      if (state_q == FULL) begin
        state_d = FIRE;
        enter_d = 1'b1;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
      end
    end else if (key_dig) begin
      // A digit arriving with the code already full is dropped without touching the timer.
      if (state_q != FULL) begin
        buf_d   = (buf_q << 4) | W'(kp.key_digit);
        cnt_d   = cnt_q + CW'(1);
        timer_d = '0;
        state_d = (cnt_q + CW'(1) == NFULL) ? FULL : COLLECT;
      end
    end else if (state_q != IDLE) begin
      if ((TIMEOUT_CYCLES != 0) && (timer_q == TMAX)) begin
        state_d = IDLE;
        to_d    = 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
      end else if (timer_q != '1) begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign kp.key_out   = buf_q;
  assign kp.enter_out = enter_q;
  assign kp.digit_cnt = cnt_q;
  assign kp.entry_err = err_q;
  assign kp.timeout   = to_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a digit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_keypad_entry;
  localparam int N = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if #(.NUM_DIGITS(N)) kp();
  keypad_entry #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .kp(kp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the digits held, cycles since last accepted key, pending pulses.
  int q[$];
  int idle_cycles = 0;
  bit m_fire = 0, m_err = 0, m_to = 0, started = 0;

  function automatic logic [7:0] code_of();
    int c = 0;
    foreach (q[i]) c = (c * 16 + q[i]) % 256;
    return 8'(c);
  endfunction

  always @(posedge clk) begin
    m_err = 0;
    m_to  = 0;
    if (!rst_n) begin
      q.delete(); m_fire = 0; idle_cycles = 0;
    end else if (m_fire) begin
      m_fire = 0; q.delete(); idle_cycles = 0;
    end else if (kp.lock_busy) begin
      q.delete(); idle_cycles = 0;
    end else if (kp.key_valid && kp.key_kind == 2'd1) begin
      q.delete(); idle_cycles = 0;
    end else if (kp.key_valid && kp.key_kind == 2'd2) begin
      if (q.size() == N) m_fire = 1;
      else begin m_err = 1; q.delete(); end
      idle_cycles = 0;
    end else if (kp.key_valid && kp.key_kind == 2'd0) begin
      if (q.size() < N) begin q.push_back(int'(kp.key_digit)); idle_cycles = 0; end
    end else if (q.size() > 0) begin
      if (idle_cycles == T - 1) begin m_to = 1; q.delete(); idle_cycles = 0; end
      else idle_cycles++;
    end
    started = 1;
  end

  always @(negedge clk) begin
    logic [12:0] exp_v, got_v;
    if (started) begin
      exp_v = {code_of(), m_fire, 2'(q.size()), m_err, m_to};
      got_v = {kp.key_out, kp.enter_out, kp.digit_cnt, kp.entry_err, kp.timeout};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t got key=%h ent=%b cnt=%0d err=%b to=%b need key=%h ent=%b cnt=%0d err=%b to=%b",
                 $time, got_v[12:5], got_v[4], got_v[3:2], got_v[1], got_v[0],
                 exp_v[12:5], exp_v[4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
      total++;
      if (!$onehot0({kp.enter_out, kp.entry_err, kp.timeout})) begin
        bad++;
        $display("FAIL pulse_excl t=%0t got ent/err/to=%b%b%b need at most one",
                 $time, kp.enter_out, kp.entry_err, kp.timeout);
      end
    end
  end

  task automatic lit(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] kind, input logic [3:0] dig);
    kp.key_valid = 1'b1;
    kp.key_kind  = kind;
    kp.key_digit = dig;
    tick();
    kp.key_valid = 1'b0;
  endtask

  initial begin
    int pv;
    kp.key_valid = 1'b0;
    kp.key_kind  = 2'd0;
    kp.key_digit = 4'd0;
    kp.lock_busy = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    lit("reset_key", int'(kp.key_out), 0);
    lit("reset_cnt", int'(kp.digit_cnt), 0);
    lit("reset_pulses", int'({kp.enter_out, kp.entry_err, kp.timeout}), 0);
    rst_n = 1'b1;
    tick();

    press(2'd0, 4'hA); press(2'd0, 4'h5);
    lit("t1_cnt", int'(kp.digit_cnt), 2);
    press(2'd2, 4'h0);
    lit("t1_enter", int'(kp.enter_out), 1);
    lit("t1_key", int'(kp.key_out), 8'hA5);
    tick();
    lit("t1_after", int'({kp.key_out, kp.enter_out, kp.digit_cnt}), 0);

    press(2'd0, 4'h3); press(2'd2, 4'h0);
    lit("t2_err", int'(kp.entry_err), 1);
    lit("t2_enter", int'(kp.enter_out), 0);
    lit("t2_cnt", int'(kp.digit_cnt), 0);
    tick();
    lit("t2_err_gone", int'(kp.entry_err), 0);

    press(2'd0, 4'h1); press(2'd0, 4'h2); press(2'd0, 4'h7);
    lit("t3_drop", int'(kp.key_out), 8'h12);
    press(2'd2, 4'h0);
    lit("t3_fire", int'({kp.enter_out, kp.key_out}), 9'h112);
    tick();

    press(2'd0, 4'hC); press(2'd1, 4'h0);
    lit("t4_clear", int'({kp.key_out, kp.digit_cnt, kp.enter_out, kp.entry_err, kp.timeout}), 0);
    press(2'd0, 4'h0); press(2'd0, 4'hF); press(2'd2, 4'h0);
    lit("t4_fire", int'({kp.enter_out, kp.key_out}), 9'h10F);
    tick();

    press(2'd0, 4'h9);
    repeat (7) tick();
    lit("t5_pre", int'({kp.timeout, kp.digit_cnt}), 1);
    tick();
    lit("t5_timeout", int'(kp.timeout), 1);
    lit("t5_cnt", int'(kp.digit_cnt), 0);
    tick();
    press(2'd0, 4'h9);
    repeat (7) tick();
    press(2'd0, 4'h4);
    lit("t5_key_wins", int'({kp.timeout, kp.digit_cnt}), 2);
    lit("t5_key", int'(kp.key_out), 8'h94);
    press(2'd1, 4'h0);

    press(2'd0, 4'hB);
    kp.lock_busy = 1'b1;
    tick();
    lit("t6_busy_cnt", int'(kp.digit_cnt), 0);
    press(2'd0, 4'h3);
    lit("t6_busy_ign", int'({kp.digit_cnt, kp.key_out}), 0);
    kp.lock_busy = 1'b0;
    press(2'd0, 4'h1);
    lit("t6_held", int'(kp.digit_cnt), 1);
    rst_n = 1'b0;
    tick();
    lit("t6_reset", int'({kp.key_out, kp.enter_out, kp.digit_cnt, kp.entry_err, kp.timeout}), 0);
    rst_n = 1'b1;

    pv = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) pv = (($urandom_range(0, 2) == 0) ? 4 : (($urandom_range(0, 1) == 0) ? 35 : 75));
      kp.key_valid = ($urandom_range(0, 99) < pv);
      kp.key_kind  = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
      kp.key_digit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) kp.lock_busy = ~kp.lock_busy;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    kp.key_valid = 1'b0;
    kp.lock_busy = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
